// File: rtl/dino_timer_pkg.sv
// Shared types and helpers for the dino obstacle timers.
// Holds the FSM state enum, reload-value construction and parameter legality.
package dino_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Upper (width - seedBits) bits forced to one, low seedBits taken from loadValue.
    function automatic logic [63:0] reload_of(input int width, input int seedBits,
                                              input logic [63:0] loadValue);
        logic [63:0] wMask;
        logic [63:0] sMask;
        wMask = (64'd1 << width) - 64'd1;
        sMask = (64'd1 << seedBits) - 64'd1;
        return (wMask & ~sMask) | (loadValue & sMask);
    endfunction

    function automatic bit params_ok(input int width, input int seedBits, input int prescale);
        return (seedBits >= 1) && (seedBits < width) && (width <= 63) && (prescale >= 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by PRESCALE and emits a one-cycle tick.
// Collapses to a plain wire when PRESCALE is 1.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{clock, reset, clear};
            assign tick     = enable;
        end else begin : g_count
            localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] r_pre;

            // Clear dominates so a fresh load always starts a full prescale period.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_pre <= '0;
                end else if (clear) begin
                    r_pre <= '0;
                end else if (enable) begin
                    r_pre <= (r_pre == LAST) ? '0 : r_pre + 1'b1;
                end
            end

            assign tick = enable && (r_pre == LAST);
        end
    endgenerate

endmodule

// File: rtl/obstacle_spawn_timer.sv
// Down-counting obstacle spawn timer with partly random reload and one-shot/periodic modes.
// Emits a single-cycle expire pulse when an exhausted count sees a prescaled tick.
module obstacle_spawn_timer
    import dino_timer_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int SEED_BITS = 2,
    parameter int PRESCALE  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load_en,
    input  logic [SEED_BITS-1:0] load_value,
    input  logic                 auto_reload,
    output logic [WIDTH-1:0]     count,
    output logic                 expire,
    output logic                 running
);

    generate
        if (!params_ok(WIDTH, SEED_BITS, PRESCALE)) begin : g_bad_params
            $error("obstacle_spawn_timer: illegal WIDTH/SEED_BITS/PRESCALE combination");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_expire;

    logic [WIDTH-1:0] w_reload;
    logic             w_tick;
    logic             w_preClear;

    assign w_reload   = WIDTH'(reload_of(WIDTH, SEED_BITS, 64'(load_value)));
    assign w_preClear = load_en || (r_state != RUN);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .clear (w_preClear),
        .tick  (w_tick)
    );

    // A load beats the terminal event, so a coincident load never pulses expire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            if (load_en) begin
                r_count <= w_reload;
                r_state <= RUN;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (enable && auto_reload) begin
                            r_count <= w_reload;
                            r_state <= RUN;
                        end else begin
                            r_count <= '0;
                        end
                    end
                    RUN: begin
                        if (w_tick) begin
                            if (r_count == '0) begin
                                r_expire <= 1'b1;
                                if (auto_reload) begin
                                    r_count <= w_reload;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end else begin
                                r_count <= r_count - 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign count   = r_count;
    assign expire  = r_expire;
    assign running = (r_state == RUN);

endmodule

// File: tb/tb_obstacle_spawn_timer.sv
// Scoreboard bench for obstacle_spawn_timer using a PRESCALE=1 and a PRESCALE=3 instance.
// Stimulus queues cycle-stamped expectations; monitors compare them as the cycles arrive.
module tb_obstacle_spawn_timer;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       run;
        logic       exp;
    } expect_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic       en1 = 1'b0, ld1 = 1'b0, auto1 = 1'b0;
    logic [1:0] lv1 = 2'b00;
    logic [3:0] count1;
    logic       expire1, running1;

    logic       en3 = 1'b0, ld3 = 1'b0, auto3 = 1'b0;
    logic [1:0] lv3 = 2'b00;
    logic [3:0] count3;
    logic       expire3, running3;

    expect_t q1[$];
    expect_t q3[$];

    obstacle_spawn_timer #(.WIDTH(4), .SEED_BITS(2), .PRESCALE(1)) dut1 (
        .clock(clock), .reset(reset), .enable(en1), .load_en(ld1), .load_value(lv1),
        .auto_reload(auto1), .count(count1), .expire(expire1), .running(running1)
    );

    obstacle_spawn_timer #(.WIDTH(4), .SEED_BITS(2), .PRESCALE(3)) dut3 (
        .clock(clock), .reset(reset), .enable(en3), .load_en(ld3), .load_value(lv3),
        .auto_reload(auto3), .count(count3), .expire(expire3), .running(running3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic pushExp(input int d, input int c, input int cnt, input logic run, input logic exp);
        expect_t e;
        e.cyc = c;
        e.cnt = 4'(cnt);
        e.run = run;
        e.exp = exp;
        if (d == 1) q1.push_back(e);
        else        q3.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input expect_t e,
                               input logic [3:0] cnt, input logic run, input logic exp);
        checks++;
        if (cnt !== e.cnt || run !== e.run || exp !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s @%0d count got %0d want %0d, running got %b want %b, expire got %b want %b",
                     tag, e.cyc, cnt, e.cnt, run, e.run, exp, e.exp);
        end
    endtask

    task automatic monitorDut(input int d, input logic [3:0] cnt, input logic run, input logic exp);
        expect_t e;
        bit      expOk;
        string   tag;
        expOk = 1'b0;
        tag   = (d == 1) ? "dut1" : "dut3";
        while (1) begin
            if (d == 1) begin
                if (q1.size() == 0 || q1[0].cyc > cyc) break;
                e = q1.pop_front();
            end else begin
                if (q3.size() == 0 || q3[0].cyc > cyc) break;
                e = q3.pop_front();
            end
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s missed expectation for cycle %0d (now %0d)", tag, e.cyc, cyc);
            end else begin
                checkOutput(tag, e, cnt, run, exp);
                if (e.exp) expOk = 1'b1;
            end
        end
        if (exp && !expOk) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s spurious expire @%0d got 1 want 0", tag, cyc);
        end
    endtask

    // Cycle monitor: samples well after each rising edge.
    always @(posedge clock) begin
        #2;
        monitorDut(1, count1, running1, expire1);
        monitorDut(3, count3, running3, expire3);
    end

    // Reset monitor: outputs must clear before the next edge arrives.
    always @(posedge reset) begin
        expect_t z;
        #1;
        z.cyc = cyc;
        z.cnt = 4'd0;
        z.run = 1'b0;
        z.exp = 1'b0;
        checkOutput("reset1", z, count1, running1, expire1);
        checkOutput("reset3", z, count3, running3, expire3);
    end

    task automatic applyStimulus(input int d, input logic ld, input logic [1:0] lv,
                                 input logic auto, input logic en);
        if (d == 1) begin
            ld1 = ld; lv1 = lv; auto1 = auto; en1 = en;
        end else begin
            ld3 = ld; lv3 = lv; auto3 = auto; en3 = en;
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int l;
        int base;

        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Idle after reset with enable low: everything stays at zero.
        base = cyc;
        for (int i = 1; i <= 20; i++) begin
            pushExp(1, base + i, 0, 1'b0, 1'b0);
            pushExp(3, base + i, 0, 1'b0, 1'b0);
        end
        waitUntil(base + 21);

        // One-shot, RELOAD = 13, PRESCALE = 1.
        applyStimulus(1, 1'b1, 2'b01, 1'b0, 1'b1);
        l = cyc + 1;
        pushExp(1, l,      13, 1'b1, 1'b0);
        pushExp(1, l + 7,   6, 1'b1, 1'b0);
        pushExp(1, l + 13,  0, 1'b1, 1'b0);
        pushExp(1, l + 14,  0, 1'b0, 1'b1);
        pushExp(1, l + 15,  0, 1'b0, 1'b0);
        pushExp(1, l + 20,  0, 1'b0, 1'b0);
        @(negedge clock);
        applyStimulus(1, 1'b0, 2'b01, 1'b0, 1'b1);
        waitUntil(l + 21);
        applyStimulus(1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Auto-reload, RELOAD = 12, PRESCALE = 3: period 39.
        applyStimulus(3, 1'b1, 2'b00, 1'b1, 1'b1);
        l = cyc + 1;
        pushExp(3, l, 12, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            pushExp(3, l + 39 * (k - 1) + 3, 11, 1'b1, 1'b0);
            pushExp(3, l + 39 * k - 1,        0, 1'b1, 1'b0);
            pushExp(3, l + 39 * k,           12, 1'b1, 1'b1);
            pushExp(3, l + 39 * k + 1,       12, 1'b1, 1'b0);
        end
        @(negedge clock);
        applyStimulus(3, 1'b0, 2'b00, 1'b1, 1'b1);
        waitUntil(l + 119);
        applyStimulus(3, 1'b0, 2'b00, 1'b0, 1'b0);

        // Pause: RELOAD = 15, enable low for 5 edges at count 7.
        applyStimulus(1, 1'b1, 2'b11, 1'b0, 1'b1);
        l = cyc + 1;
        pushExp(1, l,      15, 1'b1, 1'b0);
        pushExp(1, l + 8,   7, 1'b1, 1'b0);
        pushExp(1, l + 10,  7, 1'b1, 1'b0);
        pushExp(1, l + 13,  7, 1'b1, 1'b0);
        pushExp(1, l + 14,  6, 1'b1, 1'b0);
        pushExp(1, l + 20,  0, 1'b1, 1'b0);
        pushExp(1, l + 21,  0, 1'b0, 1'b1);
        pushExp(1, l + 22,  0, 1'b0, 1'b0);
        @(negedge clock);
        applyStimulus(1, 1'b0, 2'b11, 1'b0, 1'b1);
        waitUntil(l + 8);
        applyStimulus(1, 1'b0, 2'b11, 1'b0, 1'b0);
        waitUntil(l + 13);
        applyStimulus(1, 1'b0, 2'b11, 1'b0, 1'b1);
        waitUntil(l + 23);

        // Collision: reload on the terminal cycle, then async reset at count 9.
        applyStimulus(1, 1'b1, 2'b01, 1'b0, 1'b1);
        l = cyc + 1;
        pushExp(1, l,      13, 1'b1, 1'b0);
        pushExp(1, l + 13,  0, 1'b1, 1'b0);
        pushExp(1, l + 14, 14, 1'b1, 1'b0);
        pushExp(1, l + 15, 13, 1'b1, 1'b0);
        pushExp(1, l + 19,  9, 1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(1, 1'b0, 2'b01, 1'b0, 1'b1);
        waitUntil(l + 13);
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 1'b1);
        @(negedge clock);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 1'b1);
        waitUntil(l + 19);
        #1 reset = 1'b1;
        for (int i = 20; i <= 25; i++) pushExp(1, l + i, 0, 1'b0, 1'b0);
        pushExp(3, l + 20, 0, 1'b0, 1'b0);
        waitUntil(l + 21);
        reset = 1'b0;

        // IDLE self-load on enable && auto_reload, RELOAD = 15 with PRESCALE = 3.
        applyStimulus(3, 1'b0, 2'b11, 1'b1, 1'b1);
        pushExp(3, l + 22, 15, 1'b1, 1'b0);
        pushExp(3, l + 25, 14, 1'b1, 1'b0);
        waitUntil(l + 27);
        applyStimulus(3, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clock);

        while (q1.size() > 0) begin
            expect_t e;
            e = q1.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL dut1 unchecked expectation for cycle %0d", e.cyc);
        end
        while (q3.size() > 0) begin
            expect_t e;
            e = q3.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL dut3 unchecked expectation for cycle %0d", e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
